// File: rtl/silife_grid_stepper.sv
// silife_grid_stepper
// Holds a 32x32 Game-of-Life grid (B3/S23) and advances it one generation per step request,
// rewriting one row per clock. Rows are served combinationally to the display driver.
//
// Ports:
//   clk, reset          system clock; asynchronous active-high reset
//   i_row_select/o_cells display read port (bit c of o_cells is column c)
//   i_load_en/_row/_data row preload port, honoured only while idle
//   i_step               request one generation (ignored while busy)
//   i_wrap               1 = toroidal edges, 0 = cells outside the grid are dead
//   o_busy, o_done       generation in progress / one-cycle completion pulse
//   o_generation         completed generation count (wraps)
//   o_population         live cells in the last computed generation
//
// Optional feature: define SILIFE_GRID_STEPPER_POPULATION_EN to build the population counter;
// otherwise o_population is tied to 0.
module silife_grid_stepper #(
    parameter int unsigned GEN_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [4:0]           i_row_select,
    output logic [31:0]          o_cells,
    input  logic                 i_load_en,
    input  logic [4:0]           i_load_row,
    input  logic [31:0]          i_load_data,
    input  logic                 i_step,
    input  logic                 i_wrap,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [GEN_WIDTH-1:0] o_generation,
    output logic [10:0]          o_population
);

    typedef enum logic [1:0] {StIdle, StPrep, StRow} state_e;

    state_e               state_q, state_d;
    logic [31:0]          grid_q [32];
    logic [31:0]          prev_buf_q;   // old contents of the row above the one being rewritten
    logic [31:0]          first_buf_q;  // old row 0, needed as the wrapped neighbour of row 31
    logic [4:0]           row_ctr_q;
    logic                 done_q;
    logic [GEN_WIDTH-1:0] gen_q;

    logic                 last_row;
    logic [31:0]          below_row;
    logic [31:0]          next_row;

    // Next state of one row given the old rows above/at/below it.
    function automatic logic [31:0] life_row(input logic [31:0] above, input logic [31:0] cur,
                                             input logic [31:0] below, input logic wrap);
        logic [31:0] al, ar, cl, cr, bl, br, nxt;
        logic [3:0]  n;
        // xl[c] = x[c-1], xr[c] = x[c+1]; edge columns see the opposite edge only when wrapping
        al = {above[30:0], wrap & above[31]};
        ar = {wrap & above[0], above[31:1]};
        cl = {cur[30:0], wrap & cur[31]};
        cr = {wrap & cur[0], cur[31:1]};
        bl = {below[30:0], wrap & below[31]};
        br = {wrap & below[0], below[31:1]};
        nxt = '0;
        for (int c = 0; c < 32; c++) begin
            n = {3'b0, al[c]} + {3'b0, above[c]} + {3'b0, ar[c]} + {3'b0, cl[c]} +
                {3'b0, cr[c]} + {3'b0, bl[c]} + {3'b0, below[c]} + {3'b0, br[c]};
            nxt[c] = (n == 4'd3) || (cur[c] && (n == 4'd2));
        end
        return nxt;
    endfunction

    assign last_row = (row_ctr_q == 5'd31);

    always_comb begin
        below_row = '0;
        if (!last_row) begin
            below_row = grid_q[row_ctr_q + 5'd1];
        end else if (i_wrap) begin
            below_row = first_buf_q;
        end
        next_row = life_row(prev_buf_q, grid_q[row_ctr_q], below_row, i_wrap);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (i_step) state_d = StPrep;
            StPrep:  state_d = StRow;
            StRow:   if (last_row) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            prev_buf_q  <= '0;
            first_buf_q <= '0;
            row_ctr_q   <= '0;
            done_q      <= 1'b0;
            gen_q       <= '0;
            for (int r = 0; r < 32; r++) begin
                grid_q[r] <= '0;
            end
        end else begin
            state_q <= state_d;
            done_q  <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (i_load_en) grid_q[i_load_row] <= i_load_data;
                end
                StPrep: begin
                    first_buf_q <= grid_q[0];
                    prev_buf_q  <= i_wrap ? grid_q[31] : '0;
                    row_ctr_q   <= '0;
                end
                StRow: begin
                    grid_q[row_ctr_q] <= next_row;
                    prev_buf_q        <= grid_q[row_ctr_q];
                    row_ctr_q         <= row_ctr_q + 5'd1;
                    if (last_row) begin
                        done_q <= 1'b1;
                        gen_q  <= gen_q + GEN_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_cells      = grid_q[i_row_select];
    assign o_busy       = (state_q != StIdle);
    assign o_done       = done_q;
    assign o_generation = gen_q;

`ifdef SILIFE_GRID_STEPPER_POPULATION_EN
    function automatic logic [5:0] popcount32(input logic [31:0] v);
        logic [5:0] s;
        s = '0;
        for (int i = 0; i < 32; i++) begin
            s = s + {5'b0, v[i]};
        end
        return s;
    endfunction

    logic [10:0] pop_acc_q, pop_q, pop_sum;

    assign pop_sum = pop_acc_q + {5'b0, popcount32(next_row)};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pop_acc_q <= '0;
            pop_q     <= '0;
        end else if (state_q == StPrep) begin
            pop_acc_q <= '0;
        end else if (state_q == StRow) begin
            pop_acc_q <= pop_sum;
            if (last_row) pop_q <= pop_sum;
        end
    end

    assign o_population = pop_q;
`else
    assign o_population = '0;
`endif

endmodule

// File: tb/tb_silife_grid_stepper.sv
// Self-checking bench for silife_grid_stepper: a table of load/step/expect scenarios plus
// hand-written sequences for timing, held step, collisions, reset mid-step and counter wrap.
module tb_silife_grid_stepper;

    localparam int unsigned GW = 3;  // small counter so the wrap is reachable

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [4:0]    i_row_select = '0;
    logic [31:0]   o_cells;
    logic          i_load_en = 1'b0;
    logic [4:0]    i_load_row = '0;
    logic [31:0]   i_load_data = '0;
    logic          i_step = 1'b0;
    logic          i_wrap = 1'b0;
    logic          o_busy;
    logic          o_done;
    logic [GW-1:0] o_generation;
    logic [10:0]   o_population;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    silife_grid_stepper #(.GEN_WIDTH(GW)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_row_select (i_row_select),
        .o_cells      (o_cells),
        .i_load_en    (i_load_en),
        .i_load_row   (i_load_row),
        .i_load_data  (i_load_data),
        .i_step       (i_step),
        .i_wrap       (i_wrap),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_generation (o_generation),
        .o_population (o_population)
    );

    typedef struct {
        logic            wrap;
        int              steps;
        logic [2:0][4:0]  lrow;
        logic [2:0][31:0] ldat;
        logic [2:0][4:0]  crow;
        logic [2:0][31:0] cexp;
        int              pop;
    } scen_t;

    scen_t scen [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic load_row(input logic [4:0] row, input logic [31:0] data);
        @(negedge clk);
        i_load_en   = 1'b1;
        i_load_row  = row;
        i_load_data = data;
        @(negedge clk);
        i_load_en   = 1'b0;
    endtask

    // Samples 40 negedges starting just after the step was taken.
    task automatic watch(output int busy_n, output int done_n);
        busy_n = 0;
        done_n = 0;
        for (int k = 0; k < 40; k++) begin
            busy_n += int'(o_busy);
            done_n += int'(o_done);
            @(negedge clk);
        end
    endtask

    task automatic do_step(output int busy_n, output int done_n);
        @(negedge clk);
        i_step = 1'b1;
        @(negedge clk);
        i_step = 1'b0;
        watch(busy_n, done_n);
    endtask

    task automatic check_row(input string name, input logic [4:0] row, input logic [31:0] exp);
        i_row_select = row;
        #1;
        check(name, 64'(o_cells), 64'(exp));
    endtask

    task automatic grid_pop(output int p);
        p = 0;
        for (int r = 0; r < 32; r++) begin
            i_row_select = 5'(r);
            #1;
            p += $countones(o_cells);
        end
    endtask

    function automatic int exp_population(input int p);
`ifdef SILIFE_GRID_STEPPER_POPULATION_EN
        return p;
`else
        return 0;
`endif
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int busy_n, done_n, p, idle, dones;

        scen[0] = '{1'b0, 1, {5'd4, 5'd5, 5'd6}, {32'h20, 32'h20, 32'h20},
                    {5'd4, 5'd5, 5'd6}, {32'h0, 32'h70, 32'h0}, 3};
        scen[1] = '{1'b0, 2, {5'd4, 5'd5, 5'd6}, {32'h20, 32'h20, 32'h20},
                    {5'd4, 5'd5, 5'd6}, {32'h20, 32'h20, 32'h20}, 3};
        scen[2] = '{1'b1, 1, {5'd0, 5'd20, 5'd21}, {32'h80000003, 32'h0, 32'h0},
                    {5'd31, 5'd0, 5'd1}, {32'h1, 32'h1, 32'h1}, 3};
        scen[3] = '{1'b0, 1, {5'd0, 5'd20, 5'd21}, {32'h80000003, 32'h0, 32'h0},
                    {5'd31, 5'd0, 5'd1}, {32'h0, 32'h0, 32'h0}, 0};
        scen[4] = '{1'b0, 3, {5'd10, 5'd11, 5'd12}, {32'h18000, 32'h18000, 32'h0},
                    {5'd10, 5'd11, 5'd12}, {32'h18000, 32'h18000, 32'h0}, 4};
        scen[5] = '{1'b1, 1, {5'd30, 5'd31, 5'd0}, {32'h20, 32'h20, 32'h20},
                    {5'd30, 5'd31, 5'd0}, {32'h0, 32'h70, 32'h0}, 3};
        scen[6] = '{1'b0, 1, {5'd30, 5'd31, 5'd0}, {32'h20, 32'h20, 32'h20},
                    {5'd30, 5'd31, 5'd0}, {32'h0, 32'h0, 32'h0}, 0};

        // Reset state
        #2;
        check("reset_busy", 64'(o_busy), 64'd0);
        check("reset_done", 64'(o_done), 64'd0);
        check("reset_gen", 64'(o_generation), 64'd0);
        check("reset_pop", 64'(o_population), 64'd0);
        grid_pop(p);
        check("reset_grid", 64'(p), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Table-driven scenarios
        for (int s = 0; s < 7; s++) begin
            do_reset();
            i_wrap = scen[s].wrap;
            for (int j = 0; j < 3; j++) load_row(scen[s].lrow[j], scen[s].ldat[j]);
            for (int n = 0; n < scen[s].steps; n++) begin
                do_step(busy_n, done_n);
                check($sformatf("s%0d_busy_cycles", s), 64'(busy_n), 64'd33);
                check($sformatf("s%0d_done_pulses", s), 64'(done_n), 64'd1);
            end
            for (int j = 0; j < 3; j++) begin
                check_row($sformatf("s%0d_row%0d", s, scen[s].crow[j]), scen[s].crow[j],
                          scen[s].cexp[j]);
            end
            grid_pop(p);
            check($sformatf("s%0d_grid_live", s), 64'(p), 64'(scen[s].pop));
            check($sformatf("s%0d_gen", s), 64'(o_generation), 64'(scen[s].steps % 8));
            check($sformatf("s%0d_population", s), 64'(o_population),
                  64'(exp_population(scen[s].pop)));
        end

        // i_step held high: back-to-back generations, one idle cycle between
        do_reset();
        i_wrap = 1'b0;
        load_row(5'd4, 32'h20);
        load_row(5'd5, 32'h20);
        load_row(5'd6, 32'h20);
        @(negedge clk);
        i_step = 1'b1;
        idle = 0;
        dones = 0;
        busy_n = 0;
        for (int k = 0; k < 100 && dones < 2; k++) begin
            @(negedge clk);
            if (o_busy) busy_n++;
            else if (busy_n > 0) idle++;
            if (o_done) begin
                dones++;
                if (dones == 2) i_step = 1'b0;
            end
        end
        i_step = 1'b0;
        check("held_dones", 64'(dones), 64'd2);
        check("held_idle_cycles", 64'(idle), 64'd2);
        check("held_busy_cycles", 64'(busy_n), 64'd66);
        check("held_gen", 64'(o_generation), 64'd2);
        check_row("held_row5", 5'd5, 32'h20);
        check_row("held_row4", 5'd4, 32'h20);

        // Load and step while busy are ignored
        do_reset();
        load_row(5'd4, 32'h20);
        load_row(5'd5, 32'h20);
        load_row(5'd6, 32'h20);
        @(negedge clk);
        i_step = 1'b1;
        @(negedge clk);
        i_step = 1'b0;
        busy_n = 0;
        done_n = 0;
        for (int k = 0; k < 40; k++) begin
            if (k == 10) begin
                i_load_en   = 1'b1;
                i_load_row  = 5'd7;
                i_load_data = 32'hFFFF_FFFF;
                i_step      = 1'b1;
            end
            if (k == 12) begin
                i_load_en = 1'b0;
                i_step    = 1'b0;
            end
            busy_n += int'(o_busy);
            done_n += int'(o_done);
            @(negedge clk);
        end
        check("coll_busy_cycles", 64'(busy_n), 64'd33);
        check("coll_done_pulses", 64'(done_n), 64'd1);
        check("coll_gen", 64'(o_generation), 64'd1);
        check_row("coll_row7", 5'd7, 32'h0);
        check_row("coll_row5", 5'd5, 32'h70);

        // Simultaneous load + step in idle steps the loaded data
        do_reset();
        @(negedge clk);
        i_load_en   = 1'b1;
        i_load_row  = 5'd5;
        i_load_data = 32'h70;
        i_step      = 1'b1;
        @(negedge clk);
        i_load_en = 1'b0;
        i_step    = 1'b0;
        watch(busy_n, done_n);
        check("ls_done_pulses", 64'(done_n), 64'd1);
        check_row("ls_row4", 5'd4, 32'h20);
        check_row("ls_row5", 5'd5, 32'h20);
        check_row("ls_row6", 5'd6, 32'h20);

        // Reset in the middle of a step
        do_reset();
        load_row(5'd4, 32'h20);
        load_row(5'd5, 32'h20);
        load_row(5'd6, 32'h20);
        @(negedge clk);
        i_step = 1'b1;
        @(negedge clk);
        i_step = 1'b0;
        repeat (16) @(negedge clk);
        check("mid_busy_before", 64'(o_busy), 64'd1);
        reset = 1'b1;
        #1;
        check("mid_busy", 64'(o_busy), 64'd0);
        check("mid_done", 64'(o_done), 64'd0);
        check("mid_gen", 64'(o_generation), 64'd0);
        check("mid_pop", 64'(o_population), 64'd0);
        grid_pop(p);
        check("mid_grid", 64'(p), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        do_step(busy_n, done_n);
        check("mid_after_done", 64'(done_n), 64'd1);
        check("mid_after_gen", 64'(o_generation), 64'd1);
        grid_pop(p);
        check("mid_after_grid", 64'(p), 64'd0);

        // Generation counter wraps modulo 2^GW
        do_reset();
        dones = 0;
        for (int n = 0; n < 8; n++) begin
            do_step(busy_n, done_n);
            dones += done_n;
        end
        check("wrap_dones", 64'(dones), 64'd8);
        check("wrap_gen0", 64'(o_generation), 64'd0);
        do_step(busy_n, done_n);
        check("wrap_gen1", 64'(o_generation), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
